// File: rtl/md_unit_e.sv
// rtl/md_unit_e.sv - execute-stage multiply/divide unit with HI/LO registers
//
// Ports:
//   Clock         rising-edge clock
//   Reset         synchronous active-low reset
//   V1_E, V2_E    forwarded rs / rt operands
//   MD_Op         0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   Start         E-stage instruction is an MD op this cycle
//   Busy          multi-cycle operation in progress (hazard unit stalls on it)
//   HI, LO        architectural HI/LO registers

module md_unit_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] V1_E,
    input  logic [31:0] V2_E,
    input  logic [2:0]  MD_Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [2:0]       op_q;

    logic             start_md;
    logic             last_cycle;
    logic             div_by_zero;
    logic [63:0]      result;

    // A multi-cycle op is only accepted from IDLE; Start during RUN is dropped.
    always_comb begin
        start_md   = (state == IDLE) && Start && (MD_Op >= OP_MULT) && (MD_Op <= OP_DIVU);
        last_cycle = (state == RUN) && (cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_md)   state_next = RUN;
            RUN:     if (last_cycle) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state == RUN);
    end

    // Result is computed combinationally from the captured operands; only the
    // commit edge is architectural.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        div_by_zero = (op_b == 32'd0);
        // Sign extension to 64 bits makes the low 64 bits of the product the signed product.
        prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u = {32'd0, op_a} * {32'd0, op_b};
        // Divisor forced to 1 when zero just to keep the dividers well defined;
        // the result is discarded in that case.
        safe_b = div_by_zero ? 32'd1 : op_b;
        uq     = op_a / safe_b;
        ur     = op_a % safe_b;
        // Signed division through magnitudes: 0x80000000 has magnitude 0x80000000
        // as an unsigned value, so the overflow case falls out naturally.
        mag_a  = op_a[31] ? (~op_a + 32'd1) : op_a;
        mag_b  = div_by_zero ? 32'd1 : (op_b[31] ? (~op_b + 32'd1) : op_b);
        sq_mag = mag_a / mag_b;
        sr_mag = mag_a % mag_b;
        sq     = (op_a[31] ^ op_b[31]) ? (~sq_mag + 32'd1) : sq_mag;
        sr     = op_a[31] ? (~sr_mag + 32'd1) : sr_mag;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {sr, sq};
            OP_DIVU:  result = {ur, uq};
            default:  result = {HI, LO};
        endcase
    end

    // Datapath: operand capture, countdown, HI/LO writes
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt  <= '0;
            op_a <= '0;
            op_b <= '0;
            op_q <= '0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (start_md) begin
                op_a <= V1_E;
                op_b <= V2_E;
                op_q <= MD_Op;
                cnt  <= (MD_Op == OP_MULT || MD_Op == OP_MULTU) ? CNT_W'(MULT_CYCLES)
                                                                 : CNT_W'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (last_cycle) begin
                if (!(div_by_zero && (op_q == OP_DIV || op_q == OP_DIVU))) begin
                    HI <= result[63:32];
                    LO <= result[31:0];
                end
            end else if (state == IDLE && Start) begin
                if (MD_Op == OP_MTHI) HI <= V1_E;
                if (MD_Op == OP_MTLO) LO <= V1_E;
            end
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// tb/tb_md_unit_e.sv - scoreboard bench for md_unit_e

module tb_md_unit_e;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clock;
    logic        Reset;
    logic [31:0] V1_E;
    logic [31:0] V2_E;
    logic [2:0]  MD_Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clock(Clock), .Reset(Reset), .V1_E(V1_E), .V2_E(V2_E),
        .MD_Op(MD_Op), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic from the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        logic [63:0] p;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b};     hi = p[63:32]; lo = p[31:0]; end
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            3'd4: if (b != 0) begin lo = a / b; hi = a % b; end
            default: ;
        endcase
    endtask

    // Monitor: every falling Busy is a commit; compare against the oldest expectation.
    int          busy_cnt  = 0;
    logic        prev_busy = 1'b0;
    logic        moved     = 1'b0;
    logic [31:0] hi_start, lo_start;

    always @(negedge Clock) begin
        if (!Reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (Busy) begin
                if (!prev_busy) begin
                    hi_start = HI;
                    lo_start = LO;
                    moved    = 1'b0;
                end else if (HI !== hi_start || LO !== lo_start) begin
                    moved = 1'b1;
                end
                busy_cnt++;
                if (busy_cnt > 4 * DIV_N) begin
                    check("busy_stuck", 32'(busy_cnt), 32'(DIV_N));
                    busy_cnt = 0;
                end
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("busy_len", 32'(busy_cnt), 32'(e.n));
                    check("commit_hi", HI, e.hi);
                    check("commit_lo", LO, e.lo);
                    check("hilo_held_during_busy", {31'd0, moved}, 32'd0);
                end
                busy_cnt = 0;
            end
            prev_busy = Busy;
        end
    end

    // Issue Start for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge Clock); #1;
        Start = 1'b1; MD_Op = op; V1_E = a; V2_E = b;
        @(posedge Clock); #1;
        Start = 1'b0; MD_Op = 3'($urandom); V1_E = $urandom; V2_E = $urandom;
    endtask

    // Push the expected commit for a multi-cycle op and update the model.
    task automatic expect_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model(op, a, b, m_hi, m_lo);
        e.hi = m_hi;
        e.lo = m_lo;
        e.n  = (op <= 3'd2) ? MULT_N : DIV_N;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        if (op >= 3'd1 && op <= 3'd4) begin
            expect_md(op, a, b);
            repeat ((op <= 3'd2) ? MULT_N : DIV_N) @(posedge Clock);
        end else begin
            if (op == 3'd5) m_hi = a;
            if (op == 3'd6) m_lo = a;
            check("mt_busy", {31'd0, Busy}, 32'd0);
            check("mt_hi", HI, m_hi);
            check("mt_lo", LO, m_lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        Reset = 1'b0; Start = 1'b0; MD_Op = 3'd0; V1_E = 32'd0; V2_E = 32'd0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        Reset = 1'b1;

        // Directed cases
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h1111_1111, 32'd0);
        run_op(3'd6, 32'h2222_2222, 32'd0);
        run_op(3'd4, 32'h1234_5678, 32'd0);
        run_op(3'd3, 32'h7777_7777, 32'd0);
        run_op(3'd0, 32'hAAAA_AAAA, 32'd1);
        run_op(3'd7, 32'h5555_5555, 32'd1);

        // Start while busy: mthi mid-op and at the commit edge must be ignored
        issue(3'd1, 32'd7, 32'hFFFF_FFFF);
        expect_md(3'd1, 32'd7, 32'hFFFF_FFFF);
        @(posedge Clock); #1;
        Start = 1'b1; MD_Op = 3'd5; V1_E = 32'hDEAD_BEEF;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (MULT_N - 3) @(posedge Clock);
        #1;
        Start = 1'b1; MD_Op = 3'd5; V1_E = 32'hCAFE_F00D;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("commit_edge_busy", {31'd0, Busy}, 32'd0);
        check("commit_edge_hi", HI, m_hi);
        repeat (3) @(posedge Clock);
        #1;
        check("ignored_start_hi", HI, m_hi);
        check("ignored_start_busy", {31'd0, Busy}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(op, a, b);
        end

        // Reset mid-operation aborts the op; nothing commits afterwards
        run_op(3'd5, 32'h3333_3333, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("midreset_busy", {31'd0, Busy}, 32'd0);
        check("midreset_hi", HI, 32'd0);
        check("midreset_lo", LO, 32'd0);
        Reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (DIV_N + 4) @(posedge Clock);
        #1;
        check("post_reset_hi", HI, 32'd0);
        check("post_reset_lo", LO, 32'd0);
        check("post_reset_busy", {31'd0, Busy}, 32'd0);
        run_op(3'd2, 32'h0001_0000, 32'h0001_0000);

        repeat (3) @(posedge Clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
